// File: rtl/register_bist.sv
// register_bist: BIST engine for a load-enable data register (reset, pattern write/readback).
// Optional macro REG_BIST_HOLD_CHECK_EN adds a HOLD/CHOLD retention check after each CHECK.
module register_bist #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dut_out,
    output logic             dut_rst_,
    output logic             dut_load,
    output logic [WIDTH-1:0] dut_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
);
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        DRST,
        CRST,
        WRITE,
        CHECK,
        HOLD,
        CHOLD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [ERR_W-1:0] err_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] cmp_exp;
    logic             cmp_en;
    logic             launch;

    // Replicated 01, 10, 1100, 0011 and all-ones, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] pattern(input logic [2:0] i);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < WIDTH; b++) begin
            case (i)
                3'd0:    p[b] = ((b % 2) == 0);
                3'd1:    p[b] = ((b % 2) == 1);
                3'd2:    p[b] = ((b % 4) >= 2);
                3'd3:    p[b] = ((b % 4) < 2);
                default: p[b] = 1'b1;
            endcase
        end
        return p;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cmp_en    = 1'b0;
        cmp_exp   = '0;
        launch    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = DRST;
                    idx_nxt   = '0;
                end
            end
            DRST: state_nxt = CRST;
            CRST: begin
                cmp_en    = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: state_nxt = CHECK;
            CHECK: begin
                cmp_en  = 1'b1;
                cmp_exp = pattern(idx);
`ifdef REG_BIST_HOLD_CHECK_EN
                state_nxt = HOLD;
`else
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WRITE;
                    idx_nxt   = idx + 3'd1;
                end
`endif
            end
            HOLD: state_nxt = CHOLD;
            CHOLD: begin
                cmp_en  = 1'b1;
                cmp_exp = pattern(idx);
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WRITE;
                    idx_nxt   = idx + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        err_nxt = err_cnt;
        if (launch) begin
            err_nxt = '0;
        end else if (cmp_en && (dut_out != cmp_exp)) begin
            err_nxt = sat_inc(err_cnt);
        end
    end

    // Outputs are decoded from the next state so each value holds for its whole state cycle.
    always_comb begin
        data_nxt = '0;
        case (state_nxt)
            WRITE:       data_nxt = pattern(idx_nxt);
            CHECK, HOLD: data_nxt = ~pattern(idx_nxt);
            default:     data_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            err_cnt  <= '0;
            dut_rst_ <= 1'b1;
            dut_load <= 1'b0;
            dut_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            err_cnt  <= err_nxt;
            dut_rst_ <= (state_nxt != DRST);
            dut_load <= (state_nxt == WRITE);
            dut_data <= data_nxt;
            busy     <= (state_nxt != IDLE) && (state_nxt != DONE);
            done     <= (state_nxt == DONE);
            pass     <= (state_nxt == DONE) && (err_nxt == '0);
        end
    end
endmodule
